// File: rtl/mux_8_1_rr_pkg.sv
// Shared types and constants for the 8:1 round-robin multiplexer and its arbiter.
package mux_8_1_rr_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [NUM_CH-1:0] ch_mask_t;

    // Pointer value after reset, so the first search begins at channel 0.
    localparam sel_t RESET_GRANT = sel_t'(NUM_CH - 1);

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin arbiter: rotate requests so the channel after
// last_grant sits at bit 0, pick the lowest set bit, rotate the index back.
module rr_arbiter_8
    import mux_8_1_rr_pkg::*;
(
    input  ch_mask_t req,
    input  sel_t     last_grant,
    output logic     gnt_vld,
    output sel_t     gnt_idx
);

    sel_t                    start;
    sel_t                    offset;
    logic [2*NUM_CH-1:0]     req_x2;
    ch_mask_t                rot;

    always_comb begin
        // NOTE: every output of this block is assigned a default before any
        // conditional code, so no path leaves a value held and no latch forms.
        offset  = '0;
        start   = last_grant + sel_t'(1);
        req_x2  = {req, req} >> start;
        rot     = req_x2[NUM_CH-1:0];
        gnt_vld = |rot;
        // Scan downwards so the lowest requesting position is the last to write.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = sel_t'(i);
            end
        end
        gnt_idx = start + offset;
    end

endmodule

// File: rtl/mux_8_1_rr.sv
// Eight producers into one valid/ready stream with round-robin arbitration,
// a single registered output stage and a 3-bit source tag on every word.
module mux_8_1_rr
    import mux_8_1_rr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    sel_t              out_sel_q,   out_sel_d;
    sel_t              last_grant_q, last_grant_d;

    logic              load_en;
    logic              xfer;
    logic              gnt_vld;
    sel_t              gnt_idx;

    rr_arbiter_8 u_arb (
        .req        (in_valid),
        .last_grant (last_grant_q),
        .gnt_vld    (gnt_vld),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        in_ready     = '0;

        // The output register can take a word when empty or when drained now.
        load_en = !out_valid_q || out_ready;
        xfer    = load_en && gnt_vld;

        if (xfer) begin
            // Gated by rst_n so no producer sees an accept while held in reset.
            in_ready[gnt_idx] = rst_n;
            out_valid_d       = 1'b1;
            out_data_d        = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
            out_sel_d         = gnt_idx;
            last_grant_d      = gnt_idx;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sel_q    <= '0;
            last_grant_q <= RESET_GRANT;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_8_1_rr.sv
// Randomized scoreboard bench for mux_8_1_rr: a search-based reference model
// predicts grants and words; a separate monitor pops on each output handshake.
module tb_mux_8_1_rr;
    import mux_8_1_rr_pkg::*;

    localparam int DATA_W = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_sel;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                sel;
    } word_t;

    word_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_last = NUM_CH - 1;
    bit    m_occ  = 1'b0;

    always #5 clk = ~clk;

    mux_8_1_rr #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] rand_data();
        return {$urandom(), $urandom()};
    endfunction

    // Called at posedge+1: drive inputs, predict this cycle, check, then
    // advance the model across the next rising edge.
    task automatic step(input logic [NUM_CH-1:0] v, input logic r,
                        input logic [NUM_CH*DATA_W-1:0] d);
        int                g;
        bit                le;
        bit                xfer;
        logic [NUM_CH-1:0] exp_rdy;
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        le = !m_occ || r;
        g  = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_last + k) % NUM_CH;
            if (g < 0 && v[c]) g = c;
        end
        xfer    = le && (g >= 0);
        exp_rdy = xfer ? (NUM_CH'(1) << g) : '0;
        @(negedge clk);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, m_occ);
        if (m_occ && !r && sb_q.size() > 0) begin
            check("held_sel", out_sel, sb_q[0].sel);
            check("held_data", out_data, sb_q[0].data);
        end
        @(posedge clk);
        if (xfer) begin
            sb_q.push_back('{data: d[g*DATA_W +: DATA_W], sel: g});
            m_occ  = 1'b1;
            m_last = g;
        end else if (le) begin
            m_occ = 1'b0;
        end
        #1;
    endtask

    // Monitor: every output handshake must match the oldest predicted word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", out_valid, 1'b0);
            end else begin
                word_t w;
                w = sb_q.pop_front();
                check("out_sel", out_sel, w.sel);
                check("out_data", out_data, w.data);
            end
        end
    end

    initial begin
        logic [NUM_CH*DATA_W-1:0] d;

        // Reset with every channel requesting.
        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        in_data   = rand_data();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sel", out_sel, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full load: 0..7 then 0, back to back.
        repeat (9) step('1, 1'b1, rand_data());

        // Single channel 5.
        d = rand_data();
        d[5*DATA_W +: DATA_W] = 8'hA5;
        step(8'h20, 1'b1, d);
        step(8'h00, 1'b1, rand_data());

        // Backpressure: load channel 3, stall three cycles, then channel 4 wins.
        step(8'h08, 1'b1, rand_data());
        repeat (3) step('1, 1'b0, rand_data());
        step('1, 1'b1, rand_data());
        step(8'h00, 1'b1, rand_data());

        // Wrap-around: grant 6, then 2 and 6 alternate.
        step(8'h40, 1'b1, rand_data());
        repeat (3) step(8'h44, 1'b1, rand_data());

        // Random traffic with random backpressure and sparse/dense requests.
        for (int n = 0; n < 400; n++) begin
            logic [NUM_CH-1:0] v;
            v = (n % 2 == 0) ? NUM_CH'($urandom()) : NUM_CH'($urandom() & $urandom());
            step(v, $urandom_range(0, 3) != 0, rand_data());
        end

        // Asynchronous reset between edges while a word is held.
        step('1, 1'b1, rand_data());
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_sel", out_sel, 0);
        sb_q.delete();
        m_occ  = 1'b0;
        m_last = NUM_CH - 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) step('1, 1'b1, rand_data());

        // Drain and confirm every predicted word was seen.
        repeat (3) step('0, 1'b1, rand_data());
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_8_1_rr.md
Name: mux_8_1_rr

Overview:
- Eight-channel to one-stream round-robin multiplexer with valid/ready handshakes. It is the gathering end of the 1:8 demultiplexer path.
- Each output word carries a 3-bit sel tag giving its source channel. A downstream 1:8 demux can steer the word back by that tag.
- Sits between eight independent producers and one shared serial link or bus. It has one registered output stage.

Parameters:
- DATA_W, 8, width of each channel's data word and of out_data.
- NUM_CH, 8, number of input channels. Fixed at 8; exists only for readability. Must equal 2**SEL_W.
- SEL_W, 3, width of the channel tag.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  8  per-channel word available.
- in_data  input  8*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  8  per-channel accept. At most one bit is high in any cycle.
- out_valid  output  1  out_data/out_sel hold a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  DATA_W  multiplexed data word.
- out_sel  output  3  source channel index of out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - last_grant=7, so the first search starts at channel 0.
  - in_ready=0 while rst_n is low.
- load_en = !out_valid | out_ready. The output register is empty, or is being drained this cycle.
- Arbitration is combinational each cycle:
  - Search channels last_grant+1, +2, … up to last_grant+8, all mod 8.
  - The first channel with in_valid=1 is the grant g.
  - No in_valid set means no grant.
- Transfer condition: load_en and a grant exists. In that case:
  - in_ready[g]=1; all other in_ready bits are 0.
  - On the next edge: out_data<=in_data[g], out_sel<=g, out_valid<=1, last_grant<=g.
- When load_en=1 and there is no grant:
  - out_valid<=0 on the next edge.
  - out_data/out_sel hold their old values (don't-care).
  - last_grant is unchanged.
- When load_en=0 (out_valid=1 and out_ready=0):
  - in_ready is all 0.
  - out_data, out_sel, out_valid and last_grant all hold.
- in_ready depends on in_valid and out_ready combinationally. Producers must not make in_valid depend on in_ready.
- Latency and throughput:
  - Latency is 1 cycle from accepted input to out_valid.
  - Sustained throughput is 1 word/cycle while out_ready=1.
  - No bubble when the output drains and reloads in the same cycle.
- Fairness: a channel holding in_valid high is granted within 8 transfers.
- Wrap-around: after grant 7 the search starts at 0. After grant 6 with only channels 2 and 6 valid, 2 wins.
- Producer rule: a producer may drop in_valid without a transfer. The block keeps no per-channel state.
- Reset mid-operation:
  - Any held output word is discarded.
  - in_ready drops immediately.
  - The arbiter pointer returns to its reset value.
- Release of rst_n is synchronised externally. The block adds no reset synchroniser.

Decomposition:
- Shared package holds:
  - constants NUM_CH=8, SEL_W=3;
  - typedef sel_t (logic [SEL_W-1:0]);
  - typedef ch_mask_t (logic [NUM_CH-1:0]).
- One sub-module: rr_arbiter_8.
  - Inputs: req[7:0], last_grant (sel_t).
  - Outputs: gnt_vld, gnt_idx (sel_t).
  - Purely combinational rotate-priority-rotate-back.
  - The top level owns the output register, the last_grant register and the in_ready gating.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_sel=0, out_data=0, in_ready=8'h00. Release rst_n, out_ready=1 -> first out_sel=0.
- Single channel: in_valid=8'h20, ch5 data=8'hA5, out_ready=1 -> in_ready=8'h20 for one cycle. Next cycle out_valid=1, out_sel=5, out_data=8'hA5.
- Full load: all in_valid=1 with distinct data, out_ready=1 held -> out_sel sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles with no gaps, data matching each channel.
- Backpressure: out_valid=1 with out_sel=3, then out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0. Raise out_ready -> next word is from channel 4 when all are requesting.
- Wrap/priority: last grant 6, in_valid=8'h44 -> grant 2 next, then 6, then 2.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> out_valid drops immediately. After release with in_valid=8'hFF, first grant is 0.
